udma_uart_tx: RTL
=================

Name: udma_uart_tx

Overview:
- Synthesizable UART transmit path on the far side of the uDMA TX channel.
- Requests words from the uDMA TX channel with a req/gnt handshake and accepts data on valid/ready.
- Buffers accepted words in a small FIFO and serializes the low byte of each word onto the UART TX line.
- The uDMA-side VIP drives gnt/data/valid; this block drives req/ready.

Parameters:
- FIFO_DEPTH, 4, number of buffered words; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor.

Ports:
- sys_clk_i  input  1  system clock; all logic is on the rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- cfg_en_i  input  1  channel enable.
- cfg_div_i  input  DIV_W  bit period minus one, in sys_clk_i cycles.
- cfg_parity_en_i  input  1  1 = append an even-parity bit.
- cfg_stop2_i  input  1  1 = two stop bits, 0 = one stop bit.
- data_tx_req_o  output  1  request for one word from the uDMA.
- data_tx_gnt_i  input  1  grant for one requested word.
- data_tx_i  input  32  data word; only bits [7:0] are transmitted.
- data_tx_valid_i  input  1  data_tx_i is valid.
- data_tx_ready_o  output  1  FIFO can accept a word.
- tx_o  output  1  UART serial line; idle high.
- busy_o  output  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Clock and reset: one clock, sys_clk_i. Reset is rstn_i, asynchronous and active-low.
- Reset values:
  - tx_o=1; data_tx_req_o=0; data_tx_ready_o=0; busy_o=0.
  - FIFO empty; outstanding-grant counter=0; FSM in IDLE.
- data_tx_ready_o:
  - Registered; equals (FIFO count < FIFO_DEPTH) after each edge.
  - Independent of cfg_en_i, so already-granted words always land.
- Push: data_tx_valid_i && data_tx_ready_o at a rising edge writes data_tx_i into the FIFO.
- Outstanding grants (outs):
  - Incremented on data_tx_gnt_i.
  - Decremented on a push.
  - Both in the same cycle leave it unchanged.
  - Saturates at FIFO_DEPTH.
  - A push with outs=0 is accepted and outs stays 0.
- data_tx_req_o:
  - Registered.
  - High iff cfg_en_i && (FIFO count + outs) < FIFO_DEPTH, evaluated on next-state values.
  - Guarantees every granted word has a free slot.
- Serializer FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_o=1.
  - If the FIFO is non-empty: pop the head, latch byte, cfg_div_i, cfg_parity_en_i and cfg_stop2_i, then go to START.
  - Configuration changes never affect a frame in flight.
- START: tx_o=0 for one bit period, then DATA.
- DATA:
  - 8 bits, LSB first, one bit period each.
  - After bit 7, go to PARITY if parity is enabled, else STOP.
- PARITY: tx_o = XOR of the 8 data bits (even parity), one bit period.
- STOP:
  - tx_o=1 for one bit period, or two if stop2 was latched.
  - Then IDLE.
  - If the FIFO is non-empty in the last cycle of STOP, go directly to START with the new head (back-to-back frames, no idle gap).
- Bit period:
  - Down-counter loaded with the latched divisor; one bit lasts div+1 cycles.
  - div=0 gives 1 cycle per bit.
- Latency: a word pushed into an empty FIFO with the FSM in IDLE at edge N drives tx_o=0 from edge N+1.
- tx_o is registered and glitch-free.
- Simultaneous push and pop in one cycle: allowed; count is unchanged.
- Full FIFO: data_tx_ready_o=0, and a valid word is held by the sender.
- Disable mid-operation:
  - Deasserting cfg_en_i drops data_tx_req_o next cycle.
  - Granted words are still accepted.
  - The FIFO drains and the current frame completes.
- Reset mid-frame: tx_o returns to 1 immediately (asynchronously); FIFO contents are discarded.
- busy_o is registered: (FSM != IDLE) || FIFO non-empty.

Test Plan:
- Basic frame:
  - Stimulus: reset, cfg_en_i=1, div=3, no parity, 1 stop; gnt, then valid with 0x000000A5.
  - Response: tx_o carries 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles (40 cycles total), then idle high; busy_o falls 1 cycle after the stop bit ends.
- Parity and two stop bits:
  - Stimulus: send 0x07 with parity enabled, stop2=1, div=0.
  - Response: tx_o carries 0,1,1,1,0,0,0,0,0, parity 1, then 1,1 (12 cycles).
- Back-pressure:
  - Stimulus: FIFO_DEPTH=4, div=15; issue 6 grants and valids back-to-back.
  - Response: data_tx_req_o drops once count+outs=4; no word is lost; the 6 bytes appear on tx_o in order with no idle gap between frames.
- Full FIFO:
  - Stimulus: hold data_tx_valid_i high while the FIFO is full.
  - Response: data_tx_ready_o=0; the word is accepted on the edge after the first pop.
- Disable mid-frame:
  - Stimulus: drop cfg_en_i during DATA with 2 words queued.
  - Response: data_tx_req_o=0 on the next cycle; all 3 frames complete; busy_o=0 afterwards.
- Async reset:
  - Stimulus: assert rstn_i=0 mid DATA bit.
  - Response: tx_o=1 with no clock edge required; after release, outputs hold reset values and no residual frame is sent.

Source files
------------

// File: rtl/udma_uart_tx.sv
// UART transmitter fed by the uDMA TX channel through a req/gnt + valid/ready front end.
// Words land in a small FIFO; the low byte of each is serialized LSB first.
module udma_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_stop2_i,
    output logic             data_tx_req_o,
    input  logic             data_tx_gnt_i,
    input  logic [31:0]      data_tx_i,
    input  logic             data_tx_valid_i,
    output logic             data_tx_ready_o,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_outs;
    logic             r_req;
    logic             r_ready;
    logic             r_busy;
    logic             r_tx;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_idx;
    logic             r_par;
    logic             r_pen;
    logic             r_stop2;
    logic             r_stop_sec;

    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_frame_end;
    logic [7:0]       w_head;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_outs_nxt;
    logic [CW:0]      w_sum;
    logic             w_unused;

    assign w_unused    = ^data_tx_i[31:8];
    assign w_push      = data_tx_valid_i && r_ready;
    assign w_bit_end   = (r_cnt == '0);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end &&
                         (!r_stop2 || r_stop_sec);
    assign w_pop       = (r_count != '0) &&
                         ((r_state == S_IDLE) || w_frame_end);
    assign w_head      = r_mem[r_rptr];

    assign w_count_nxt = r_count + (w_push ? ONE : '0) - (w_pop ? ONE : '0);

    // Grants reserve a slot until the matching word arrives.
    always_comb begin
        w_outs_nxt = r_outs;
        if (data_tx_gnt_i && !w_push) begin
            if (r_outs < DEPTH) begin
                w_outs_nxt = r_outs + ONE;
            end
        end else if (!data_tx_gnt_i && w_push) begin
            if (r_outs != '0) begin
                w_outs_nxt = r_outs - ONE;
            end
        end
    end

    assign w_sum = {1'b0, w_count_nxt} + {1'b0, w_outs_nxt};

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_outs  <= '0;
            r_req   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_tx_i[7:0];
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_outs  <= w_outs_nxt;
            r_req   <= cfg_en_i && (w_sum < {1'b0, DEPTH});
            r_ready <= (w_count_nxt < DEPTH);
            r_busy  <= (r_state != S_IDLE) || (r_count != '0);
        end
    end

    // Serializer; config is latched at pop so a frame in flight is never disturbed.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_div      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_par      <= 1'b0;
            r_pen      <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_sec <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_shift <= w_head;
                        r_par   <= ^w_head;
                        r_div   <= cfg_div_i;
                        r_cnt   <= cfg_div_i;
                        r_pen   <= cfg_parity_en_i;
                        r_stop2 <= cfg_stop2_i;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                        r_cnt   <= r_div;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_div;
                        if (r_idx == 3'd7) begin
                            if (r_pen) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state    <= S_STOP;
                                r_tx       <= 1'b1;
                                r_stop_sec <= 1'b0;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                        r_stop_sec <= 1'b0;
                        r_cnt      <= r_div;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop2 && !r_stop_sec) begin
                            r_stop_sec <= 1'b1;
                            r_cnt      <= r_div;
                        end else if (w_pop) begin
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                            r_shift <= w_head;
                            r_par   <= ^w_head;
                            r_div   <= cfg_div_i;
                            r_cnt   <= cfg_div_i;
                            r_pen   <= cfg_parity_en_i;
                            r_stop2 <= cfg_stop2_i;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign data_tx_req_o   = r_req;
    assign data_tx_ready_o = r_ready;
    assign busy_o          = r_busy;
    assign tx_o            = r_tx;

endmodule
